// File: rtl/ball_engine_pkg.sv
// Playfield geometry, ball state encoding and small helpers shared by the ball
// engine and the drawing logic. Pure declarations: no latency, no flow control.
package ball_engine_pkg;

   localparam logic [11:0] BORDER_LEFT   = 12'd160;
   localparam logic [11:0] BORDER_RIGHT  = 12'd1120;
   localparam logic [11:0] BORDER_TOP    = 12'd128;
   localparam logic [11:0] BORDER_BOTTOM = 12'd896;

   localparam logic [11:0] PADDLE1_X = 12'd225;
   localparam logic [11:0] PADDLE2_X = 12'd1030;
   localparam logic [11:0] PADDLE_W  = 12'd25;
   localparam logic [11:0] PADDLE_H  = 12'd125;

   localparam logic [11:0] BALL_R   = 12'd15;
   localparam logic [11:0] CENTRE_X = 12'd640;
   localparam logic [11:0] CENTRE_Y = 12'd512;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAY      = 2'd1,
      POINT     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/ball_engine_tick_gen.sv
// Free-running step divider: tick is high for one cycle every TICK_DIV clocks.
// Latency: tick decodes the registered counter combinationally; never stalls.
module tick_gen #(
   parameter int unsigned TICK_DIV = 1048576,
   parameter int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   assign tick = (count == LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ball_engine.sv
// Pong ball physics, paddle collisions and scoring, advanced once per game step.
// Latency: ball and scores update the cycle after a tick (serve: next cycle); no backpressure.
module ball_engine
   import ball_engine_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 1048576,
   parameter int unsigned SPEED       = 4,
   parameter int unsigned WIN_SCORE   = 9,
   parameter int unsigned POINT_TICKS = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [10:0] P1y,
   input  logic [10:0] P2y,
   input  logic        serve,
   output logic [10:0] XDotPosition,
   output logic [10:0] YDotPosition,
   output logic [3:0]  score1,
   output logic [3:0]  score2,
   output logic        game_over
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned PT_W  = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;

   localparam logic [11:0]     SPD     = 12'(SPEED);
   localparam logic [3:0]      WIN     = 4'(WIN_SCORE);
   localparam logic [PT_W-1:0] PT_LAST = PT_W'(POINT_TICKS - 1);

   // Paddle faces the ball strikes, and the resting centre after a return.
   localparam logic [11:0] P1_FACE = PADDLE1_X + PADDLE_W;
   localparam logic [11:0] P2_FACE = PADDLE2_X;
   localparam logic [11:0] TOP_Y   = BORDER_TOP + BALL_R;
   localparam logic [11:0] BOT_Y   = BORDER_BOTTOM - BALL_R;

   logic             tick;
   logic [CNT_W-1:0] step_cnt;
   logic             unused_step_cnt;

   tick_gen #(
      .TICK_DIV(TICK_DIV),
      .CNT_W   (CNT_W)
   ) u_tick_gen (
      .clock  (clock),
      .reset_n(reset_n),
      .tick   (tick),
      .count  (step_cnt)
   );

   assign unused_step_cnt = ^step_cnt;

   state_t          state_q;
   logic [10:0]     x_q;
   logic [10:0]     y_q;
   logic            dx_neg;
   logic            dy_neg;
   logic [PT_W-1:0] pt_cnt;

   logic [11:0] x12, y12, p1y12, p2y12;
   logic        p1_hit, p2_hit, miss_l, miss_r, bot_hit, top_hit;
   logic [10:0] x_nxt, y_nxt;

   assign x12   = {1'b0, x_q};
   assign y12   = {1'b0, y_q};
   assign p1y12 = {1'b0, P1y};
   assign p2y12 = {1'b0, P2y};

   // Everything is widened to 12 bits so the left/top subtractions never wrap.
   assign p1_hit = dx_neg && (x12 - BALL_R >= P1_FACE) && (x12 - BALL_R - SPD <= P1_FACE)
                   && (y12 >= p1y12) && (y12 <= p1y12 + PADDLE_H);
   assign p2_hit = !dx_neg && (x12 + BALL_R <= P2_FACE) && (x12 + BALL_R + SPD >= P2_FACE)
                   && (y12 >= p2y12) && (y12 <= p2y12 + PADDLE_H);
   assign miss_l = dx_neg && !p1_hit && (x12 - BALL_R - SPD <= BORDER_LEFT);
   assign miss_r = !dx_neg && !p2_hit && (x12 + BALL_R + SPD >= BORDER_RIGHT);

   assign bot_hit = !dy_neg && (y12 + SPD + BALL_R >= BORDER_BOTTOM);
   assign top_hit = dy_neg && (y12 - SPD <= TOP_Y);

   assign x_nxt = p1_hit ? 11'(P1_FACE + BALL_R) :
                  p2_hit ? 11'(P2_FACE - BALL_R) :
                  dx_neg ? 11'(x12 - SPD) : 11'(x12 + SPD);
   assign y_nxt = bot_hit ? 11'(BOT_Y) :
                  top_hit ? 11'(TOP_Y) :
                  dy_neg  ? 11'(y12 - SPD) : 11'(y12 + SPD);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         x_q       <= 11'(CENTRE_X);
         y_q       <= 11'(CENTRE_Y);
         dx_neg    <= 1'b0;
         dy_neg    <= 1'b0;
         score1    <= 4'd0;
         score2    <= 4'd0;
         game_over <= 1'b0;
         pt_cnt    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (serve) begin
                  state_q <= PLAY;
                  dx_neg  <= 1'b0;
                  dy_neg  <= 1'b0;
               end
            end
            PLAY: begin
               if (tick) begin
                  if (miss_l || miss_r) begin
                     x_q     <= 11'(CENTRE_X);
                     y_q     <= 11'(CENTRE_Y);
                     pt_cnt  <= '0;
                     state_q <= POINT;
                     if (miss_l) score2 <= sat_inc(score2, WIN);
                     else        score1 <= sat_inc(score1, WIN);
                  end else begin
                     x_q    <= x_nxt;
                     y_q    <= y_nxt;
                     dx_neg <= p1_hit ? 1'b0 : (p2_hit ? 1'b1 : dx_neg);
                     dy_neg <= bot_hit ? 1'b1 : (top_hit ? 1'b0 : dy_neg);
                  end
               end
            end
            POINT: begin
               // dx is left as it was at the miss, so the restart heads at the loser.
               if (tick) begin
                  if (pt_cnt == PT_LAST) begin
                     pt_cnt <= '0;
                     dy_neg <= 1'b0;
                     if (score1 == WIN || score2 == WIN) begin
                        state_q   <= GAME_OVER;
                        game_over <= 1'b1;
                     end else begin
                        state_q <= PLAY;
                     end
                  end else begin
                     pt_cnt <= pt_cnt + PT_W'(1);
                  end
               end
            end
            GAME_OVER: begin
               if (serve) begin
                  score1    <= 4'd0;
                  score2    <= 4'd0;
                  dx_neg    <= 1'b0;
                  dy_neg    <= 1'b0;
                  game_over <= 1'b0;
                  state_q   <= PLAY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign XDotPosition = x_q;
   assign YDotPosition = y_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomised bench for ball_engine with a game-level reference model.
module tb_ball_engine;

   localparam int TD  = 4;
   localparam int PT  = 2;
   localparam int SPD = 4;
   localparam int WIN = 9;

   localparam int M_IDLE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

   logic        clock;
   logic        reset_n;
   logic [10:0] P1y, P2y;
   logic        serve;
   logic [10:0] XDotPosition, YDotPosition;
   logic [3:0]  score1, score2;
   logic        game_over;

   int total = 0;
   int bad   = 0;

   // Reference model of the game, in plain integers.
   int m_cyc, m_st, mx, my, mdx, mdy, ms1, ms2, mpt;

   ball_engine #(
      .TICK_DIV   (TD),
      .SPEED      (SPD),
      .WIN_SCORE  (WIN),
      .POINT_TICKS(PT)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .P1y         (P1y),
      .P2y         (P2y),
      .serve       (serve),
      .XDotPosition(XDotPosition),
      .YDotPosition(YDotPosition),
      .score1      (score1),
      .score2      (score2),
      .game_over   (game_over)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_cyc = 0; m_st = M_IDLE; mx = 640; my = 512;
      mdx = 1; mdy = 1; ms1 = 0; ms2 = 0; mpt = 0;
   endtask

   task automatic model_edge();
      bit tk, h1, h2;
      int p1, p2;
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      p1 = int'(P1y);
      p2 = int'(P2y);
      case (m_st)
         M_IDLE: if (serve) begin m_st = M_PLAY; mdx = 1; mdy = 1; end
         M_PLAY: if (tk) begin
            h1 = (mdx < 0) && (mx - 15 >= 250) && (mx - 15 - SPD <= 250) && (my >= p1) && (my <= p1 + 125);
            h2 = (mdx > 0) && (mx + 15 <= 1030) && (mx + 15 + SPD >= 1030) && (my >= p2) && (my <= p2 + 125);
            if (!h1 && mdx < 0 && mx - 15 - SPD <= 160) begin
               ms2 = (ms2 < WIN) ? ms2 + 1 : WIN;
               mx = 640; my = 512; mpt = 0; m_st = M_POINT;
            end else if (!h2 && mdx > 0 && mx + 15 + SPD >= 1120) begin
               ms1 = (ms1 < WIN) ? ms1 + 1 : WIN;
               mx = 640; my = 512; mpt = 0; m_st = M_POINT;
            end else begin
               if (h1)      begin mx = 265;  mdx = 1;  end
               else if (h2) begin mx = 1015; mdx = -1; end
               else mx = mx + mdx * SPD;
               if (mdy > 0 && my + SPD + 15 >= 896)      begin my = 881; mdy = -1; end
               else if (mdy < 0 && my - SPD <= 143)      begin my = 143; mdy = 1;  end
               else my = my + mdy * SPD;
            end
         end
         M_POINT: if (tk) begin
            mpt++;
            if (mpt == PT) begin
               mpt = 0; mdy = 1;
               m_st = (ms1 == WIN || ms2 == WIN) ? M_OVER : M_PLAY;
            end
         end
         default: if (serve) begin ms1 = 0; ms2 = 0; mdx = 1; mdy = 1; m_st = M_PLAY; end
      endcase
   endtask

   function automatic logic [30:0] exp_vec();
      return {11'(mx), 11'(my), 4'(ms1), 4'(ms2), (m_st == M_OVER)};
   endfunction

   function automatic string dut_str();
      return $sformatf("x=%0d y=%0d s1=%0d s2=%0d go=%0b",
                       XDotPosition, YDotPosition, score1, score2, game_over);
   endfunction

   function automatic string mdl_str();
      return $sformatf("x=%0d y=%0d s1=%0d s2=%0d go=%0b", mx, my, ms1, ms2, m_st == M_OVER);
   endfunction

   // Paddle policy: 0 = out of reach, 1 = centred on the ball, 2 = random mix.
   function automatic logic [10:0] pick(input int mode);
      case (mode)
         0:       return 11'd0;
         1:       return 11'(my - 60);
         default: return ($urandom_range(0, 1) == 1) ? 11'(my - int'($urandom_range(0, 125)))
                                                     : 11'($urandom_range(0, 1000));
      endcase
   endfunction

   task automatic set_paddles(input int m1, input int m2);
      P1y = pick(m1);
      P2y = pick(m2);
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      serve = 1'b0; P1y = 11'd0; P2y = 11'd0;
      #1 reset_n = 1'b0;
      #1;
      total++;
      if ({XDotPosition, YDotPosition, score1, score2, game_over} !== {11'd640, 11'd512, 4'd0, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_hold got %s want x=640 y=512 s1=0 s2=0 go=0", dut_str());
      end
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         cycle();
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL idle cyc=%0d got %s want %s", i, dut_str(), mdl_str());
         end
      end
   endtask

   task automatic test_serve();
      apply_reset();
      serve = 1'b1;
      cycle();
      serve = 1'b0;
      cycle(); cycle();
      total++;
      if ({XDotPosition, YDotPosition} !== {11'd640, 11'd512}) begin
         bad++; $display("FAIL serve_before_tick got %s want x=640 y=512", dut_str());
      end
      cycle();
      total++;
      if ({XDotPosition, YDotPosition} !== {11'd644, 11'd516}) begin
         bad++; $display("FAIL serve_first_tick got %s want x=644 y=516", dut_str());
      end
      total++;
      if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
         bad++; $display("FAIL serve_model got %s want %s", dut_str(), mdl_str());
      end
   endtask

   task automatic test_walls_and_paddles();
      bit seen_881 = 0, seen_143 = 0, seen_265 = 0, seen_1015 = 0;
      for (int i = 0; i < 3000; i++) begin
         set_paddles(1, 1);
         cycle();
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL rally cyc=%0d got %s want %s", i, dut_str(), mdl_str());
         end
         if (YDotPosition == 11'd881)  seen_881  = 1;
         if (YDotPosition == 11'd143)  seen_143  = 1;
         if (XDotPosition == 11'd265)  seen_265  = 1;
         if (XDotPosition == 11'd1015) seen_1015 = 1;
      end
      total++;
      if ({seen_881, seen_143, seen_265, seen_1015} !== 4'b1111) begin
         bad++; $display("FAIL rally_extremes got y881/y143/x265/x1015=%b want 1111",
                         {seen_881, seen_143, seen_265, seen_1015});
      end
   endtask

   task automatic test_left_miss();
      int n = 0;
      int s2_before = ms2;
      while (m_st != M_POINT && n < 4000) begin
         set_paddles(0, 1);
         cycle();
         n++;
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL left_miss cyc=%0d got %s want %s", n, dut_str(), mdl_str());
         end
      end
      total++;
      if ({score2, XDotPosition, YDotPosition} !== {4'(s2_before + 1), 11'd640, 11'd512}) begin
         bad++; $display("FAIL left_miss_point got %s want s2=%0d x=640 y=512", dut_str(), s2_before + 1);
      end
      n = 0;
      while (!(m_st == M_PLAY && mx != 640) && n < 200) begin
         cycle();
         n++;
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL point_hold cyc=%0d got %s want %s", n, dut_str(), mdl_str());
         end
      end
      total++;
      if ({XDotPosition, YDotPosition} !== {11'd636, 11'd516}) begin
         bad++; $display("FAIL restart_toward_p1 got %s want x=636 y=516", dut_str());
      end
   endtask

   task automatic test_game_over();
      int n = 0;
      serve = 1'b0;
      while (m_st != M_OVER && n < 20000) begin
         set_paddles(1, 0);
         cycle();
         n++;
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL to_game_over cyc=%0d got %s want %s", n, dut_str(), mdl_str());
         end
      end
      for (int i = 0; i < 6; i++) begin
         cycle();
         total++;
         if ({XDotPosition, YDotPosition, score1, game_over} !== {11'd640, 11'd512, 4'd9, 1'b1}) begin
            bad++; $display("FAIL game_over_hold got %s want x=640 y=512 s1=9 go=1", dut_str());
         end
      end
      serve = 1'b1;
      cycle();
      serve = 1'b0;
      total++;
      if ({score1, score2, game_over} !== {4'd0, 4'd0, 1'b0}) begin
         bad++; $display("FAIL game_over_serve got %s want s1=0 s2=0 go=0", dut_str());
      end
      for (int i = 0; i < 12; i++) begin
         cycle();
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL after_serve cyc=%0d got %s want %s", i, dut_str(), mdl_str());
         end
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      while (!(m_st == M_PLAY && mx != 640) && n < 400) begin
         cycle();
         n++;
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({XDotPosition, YDotPosition, score1, score2, game_over} !== {11'd640, 11'd512, 4'd0, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_mid_play got %s want x=640 y=512 s1=0 s2=0 go=0", dut_str());
      end
      apply_reset();
      serve = 1'b1;
      cycle();
      serve = 1'b0;
      n = 0;
      while (m_st != M_POINT && n < 2000) begin
         set_paddles(1, 0);
         cycle();
         n++;
      end
      cycle();
      total++;
      if ({score1, game_over} !== {4'd1, 1'b0}) begin
         bad++; $display("FAIL point_before_reset got %s want s1=1 go=0", dut_str());
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({XDotPosition, YDotPosition, score1, score2, game_over} !== {11'd640, 11'd512, 4'd0, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_mid_point got %s want x=640 y=512 s1=0 s2=0 go=0", dut_str());
      end
      apply_reset();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 5000; i++) begin
         serve = ($urandom_range(0, 15) == 0);
         set_paddles(2, 2);
         cycle();
         total++;
         if ({XDotPosition, YDotPosition, score1, score2, game_over} !== exp_vec()) begin
            bad++; $display("FAIL random cyc=%0d got %s want %s", i, dut_str(), mdl_str());
         end
      end
      serve = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1;
      serve   = 1'b0;
      P1y     = 11'd0;
      P2y     = 11'd0;
      model_reset();
      test_reset();
      test_serve();
      test_walls_and_paddles();
      test_left_miss();
      test_game_over();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
